// File: rtl/dm_pkg.sv
// dm_pkg: shared width codes and FSM state encoding for the data-memory arbiter
package dm_pkg;
    localparam logic [2:0] DIG_W  = 3'b000;
    localparam logic [2:0] DIG_H  = 3'b001;
    localparam logic [2:0] DIG_B  = 3'b010;
    localparam logic [2:0] DIG_HU = 3'b011;
    localparam logic [2:0] DIG_BU = 3'b100;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: legality check, byte-lane enables, store replication and load alignment
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  digit,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic        is_h, is_b;
    logic [31:0] sh;
    assign is_h      = digit == DIG_H || digit == DIG_HU;
    assign is_b      = digit == DIG_B || digit == DIG_BU;
    assign illegal   = digit > DIG_BU || (digit == DIG_W && addr_lo != 2'b00) || (is_h && addr_lo[0]);
    assign be        = is_b ? 4'b0001 << addr_lo : is_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    assign sh        = rdata >> {addr_lo, 3'b000};
    assign rdata_ext = digit == DIG_H  ? {{16{sh[15]}}, sh[15:0]} :
                       digit == DIG_HU ? {16'b0, sh[15:0]} :
                       digit == DIG_B  ? {{24{sh[7]}}, sh[7:0]} :
                       digit == DIG_BU ? {24'b0, sh[7:0]} : sh;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sequencing accesses to one synchronous-read data memory
module dmem_arbiter
    import dm_pkg::*;
#(
    parameter int AW         = 12,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [31:0]   r0_wdata,
    input  logic [2:0]    r0_digit,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [31:0]   r0_rdata,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [31:0]   r1_wdata,
    input  logic [2:0]    r1_digit,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [31:0]   r1_rdata,
    output logic          r1_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    logic [1:0]  state;
    logic        last_grant, win, r_we, pick, acc, illegal, addr_unused;
    logic [31:0] r_addr, r_wdata, wd, rd;
    logic [2:0]  r_digit;
    logic [3:0]  be;

    dm_lane_align u_align (
        .addr_lo   (r_addr[1:0]),
        .digit     (r_digit),
        .wdata     (r_wdata),
        .rdata     (mem_rdata),
        .illegal   (illegal),
        .be        (be),
        .wdata_rep (wd),
        .rdata_ext (rd)
    );

    // under contention the port not served last wins unless port 0 is pinned
    assign pick        = (r0_req && r1_req) ? (PRIO_FIXED ? 1'b0 : ~last_grant) : r1_req;
    assign acc         = state == ACCESS;
    assign mem_en      = acc && !illegal;
    assign mem_we      = mem_en && r_we;
    assign mem_addr    = mem_en ? r_addr[AW+1:2] : '0;
    assign mem_be      = mem_en ? be : 4'b0000;
    assign mem_wdata   = mem_en ? wd : 32'b0;
    assign r0_gnt      = acc && !win;
    assign r1_gnt      = acc && win;
    assign r0_err      = r0_gnt && illegal;
    assign r1_err      = r1_gnt && illegal;
    assign addr_unused = ^r_addr[31:AW+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win        <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'b0;
            r_wdata    <= 32'b0;
            r_digit    <= 3'b0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= 32'b0;
            r1_rdata   <= 32'b0;
        end else begin
            r0_rvalid <= state == RESP && !win;
            r1_rvalid <= state == RESP && win;
            if (state == RESP && !win) r0_rdata <= rd;
            if (state == RESP && win) r1_rdata <= rd;
            if (state == IDLE && (r0_req || r1_req)) begin
                win        <= pick;
                last_grant <= pick;
                r_we       <= pick ? r1_we : r0_we;
                r_addr     <= pick ? r1_addr : r0_addr;
                r_wdata    <= pick ? r1_wdata : r0_wdata;
                r_digit    <= pick ? r1_digit : r0_digit;
                state      <= ACCESS;
            end else if (acc) begin
                state <= (illegal || r_we) ? IDLE : RESP;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, hand sequences and random traffic against a byte-level memory model
module tb_dmem_arbiter;
    import dm_pkg::*;
    localparam int AW = 12;

    logic clk = 1'b0, reset = 1'b0;
    logic r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r0_addr = 32'b0, r0_wdata = 32'b0, r1_addr = 32'b0, r1_wdata = 32'b0;
    logic [2:0] r0_digit = 3'b0, r1_digit = 3'b0;
    logic r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err, mem_en, mem_we;
    logic [31:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0] mem_be;
    logic f_r0_gnt, f_r0_rvalid, f_r0_err, f_r1_gnt, f_r1_rvalid, f_r1_err, f_mem_en, f_mem_we;
    logic [31:0] f_r0_rdata, f_r1_rdata, f_mem_wdata;
    logic [31:0] f_mem_rdata = 32'b0;
    logic [AW-1:0] f_mem_addr;
    logic [3:0] f_mem_be;

    int nvec = 0, errs = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_digit(r0_digit),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_digit(r1_digit),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.AW(AW), .PRIO_FIXED(1'b1)) dut_f (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_digit(r0_digit),
        .r0_gnt(f_r0_gnt), .r0_rvalid(f_r0_rvalid), .r0_rdata(f_r0_rdata), .r0_err(f_r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_digit(r1_digit),
        .r1_gnt(f_r1_gnt), .r1_rvalid(f_r1_rvalid), .r1_rdata(f_r1_rdata), .r1_err(f_r1_err),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_be(f_mem_be),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
    );

    // environment memory: word-wide, byte-enabled, one-cycle read latency
    logic [31:0] tmem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) tmem[i] = 32'b0;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int i = 0; i < 4; i++) if (mem_be[i]) tmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end else if (mem_en) begin
            mem_rdata <= tmem[mem_addr];
        end
    end

    // reference model: flat byte array addressed by the in-range byte address
    logic [7:0] ref_b [0:(4<<AW)-1];
    initial for (int i = 0; i < (4 << AW); i++) ref_b[i] = 8'h00;

    function automatic int size_of(logic [2:0] d);
        return (d == DIG_W) ? 4 : (d == DIG_H || d == DIG_HU) ? 2 : (d == DIG_B || d == DIG_BU) ? 1 : 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] d);
        int n = size_of(d);
        int base = int'(a[AW+1:0]);
        logic [31:0] v = 32'b0;
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        for (int i = 0; i < n; i++) v = v | ({24'b0, ref_b[base+i]} << (8 * i));
        if ((d == DIG_H || d == DIG_B) && v[8*n-1]) v = v | ~mask[31:0];
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic [31:0] a, logic [2:0] d);
        logic [3:0] b = 4'b0;
        for (int i = 0; i < size_of(d); i++) b[(int'(a[1:0]) + i) % 4] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] ref_wd(logic [31:0] wd, logic [2:0] d);
        logic [31:0] r = 32'b0;
        int n = size_of(d);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    logic cp = 1'b0;
    logic g, og, rv, orv, er;
    logic [31:0] rdv;
    assign g   = cp ? r1_gnt : r0_gnt;
    assign og  = cp ? r0_gnt : r1_gnt;
    assign rv  = cp ? r1_rvalid : r0_rvalid;
    assign orv = cp ? r0_rvalid : r1_rvalid;
    assign er  = cp ? r1_err : r0_err;
    assign rdv = cp ? r1_rdata : r0_rdata;

    task automatic txn(input logic p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] d, input logic xerr, input logic [3:0] xbe,
                       input logic [31:0] xwd, input logic [AW-1:0] xma, input logic [31:0] xrd);
        int n;
        @(negedge clk);
        cp = p;
        if (p) begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd; r1_digit = d;
        end else begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd; r0_digit = d;
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!g && n < 8);
        r0_req = 1'b0;
        r1_req = 1'b0;
        check("gnt_latency", n, 1);
        check("other_gnt", og, 1'b0);
        check("err", er, xerr);
        check("mem_en", mem_en, !xerr);
        if (!xerr) begin
            check("mem_we", mem_we, we);
            check("mem_addr", mem_addr, xma);
            check("mem_be", mem_be, xbe);
            if (we) check("mem_wdata", mem_wdata, xwd);
        end
        if (we && !xerr) for (int i = 0; i < size_of(d); i++) ref_b[int'(a[AW+1:0]) + i] = wd[8*i +: 8];
        @(posedge clk); #1;
        check("gnt_pulse", g, 1'b0);
        check("rvalid_early", rv, 1'b0);
        if (!we && !xerr) begin
            @(posedge clk); #1;
            check("rvalid", rv, 1'b1);
            check("rdata", rdv, xrd);
            check("other_rvalid", orv, 1'b0);
        end else if (xerr) begin
            @(posedge clk); #1;
            check("err_no_rvalid", rv, 1'b0);
        end
    endtask

    typedef struct packed {
        logic p, we;
        logic [31:0] a, wd;
        logic [2:0] d;
        logic xerr;
        logic [3:0] xbe;
        logic [31:0] xwd;
        logic [11:0] xma;
        logic [31:0] xrd;
    } vec_t;

    vec_t tbl [18];
    int order [$];
    int fg0, fg1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h10,        32'hDEADBEEF, DIG_W,    1'b0, 4'b1111, 32'hDEADBEEF, 12'h004, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h13,        32'h0,        DIG_B,    1'b0, 4'b1000, 32'h0,        12'h004, 32'hFFFFFFDE};
        tbl[2]  = '{1'b0, 1'b0, 32'h12,        32'h0,        DIG_HU,   1'b0, 4'b1100, 32'h0,        12'h004, 32'h0000DEAD};
        tbl[3]  = '{1'b0, 1'b1, 32'h11,        32'h81,       DIG_B,    1'b0, 4'b0010, 32'h81818181, 12'h004, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h12,        32'h1234,     DIG_H,    1'b0, 4'b1100, 32'h12341234, 12'h004, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h10,        32'h0,        DIG_W,    1'b0, 4'b1111, 32'h0,        12'h004, 32'h123481EF};
        tbl[6]  = '{1'b0, 1'b0, 32'h10,        32'h0,        DIG_H,    1'b0, 4'b0011, 32'h0,        12'h004, 32'hFFFF81EF};
        tbl[7]  = '{1'b0, 1'b0, 32'h11,        32'h0,        DIG_BU,   1'b0, 4'b0010, 32'h0,        12'h004, 32'h00000081};
        tbl[8]  = '{1'b1, 1'b0, 32'h11,        32'h0,        DIG_B,    1'b0, 4'b0010, 32'h0,        12'h004, 32'hFFFFFF81};
        tbl[9]  = '{1'b0, 1'b1, 32'hFFFFC004,  32'hCAFEF00D, DIG_W,    1'b0, 4'b1111, 32'hCAFEF00D, 12'h001, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h4,         32'h0,        DIG_W,    1'b0, 4'b1111, 32'h0,        12'h001, 32'hCAFEF00D};
        tbl[11] = '{1'b1, 1'b0, 32'h6,         32'h0,        DIG_W,    1'b1, 4'b0000, 32'h0,        12'h000, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,         32'h0,        3'b111,   1'b1, 4'b0000, 32'h0,        12'h000, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'h13,        32'h0,        DIG_H,    1'b1, 4'b0000, 32'h0,        12'h000, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 32'h2,         32'hABCD5678, DIG_H,    1'b0, 4'b1100, 32'h56785678, 12'h000, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 32'h2,         32'h0,        DIG_H,    1'b0, 4'b1100, 32'h0,        12'h000, 32'h00005678};
        tbl[16] = '{1'b0, 1'b1, 32'h3,         32'h000000F0, DIG_B,    1'b0, 4'b1000, 32'hF0F0F0F0, 12'h000, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 32'h2,         32'h0,        DIG_H,    1'b0, 4'b1100, 32'h0,        12'h000, 32'hFFFFF078};

        repeat (2) @(negedge clk);
        check("reset_outs", |{r0_gnt, r0_rvalid, r0_rdata, r0_err, r1_gnt, r1_rvalid, r1_rdata, r1_err,
                              mem_en, mem_we, mem_addr, mem_be, mem_wdata}, 1'b0);
        check("reset_outs_fixed", |{f_r0_gnt, f_r1_gnt, f_mem_en, f_mem_be}, 1'b0);
        reset = 1'b1;

        // both ports hold reads continuously
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h0; r0_digit = DIG_W;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h4; r1_digit = DIG_W;
        fg0 = 0; fg1 = 0;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (r0_gnt) order.push_back(0);
            if (r1_gnt) order.push_back(1);
            fg0 += int'(f_r0_gnt);
            fg1 += int'(f_r1_gnt);
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        check("rr_grant_count", order.size(), 4);
        foreach (order[i]) check("rr_order", order[i], i % 2);
        check("fixed_r0_grants", fg0, 4);
        check("fixed_r1_grants", fg1, 0);
        repeat (3) @(posedge clk);

        foreach (tbl[i]) txn(tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].xerr,
                             tbl[i].xbe, tbl[i].xwd, tbl[i].xma[AW-1:0], tbl[i].xrd);

        // reset lands during RESP of a port-0 read
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10; r0_digit = DIG_W;
        @(posedge clk); #1;
        check("rst_seq_gnt", r0_gnt, 1'b1);
        r0_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_reset_outs", |{r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_rdata, r1_err,
                                    mem_en, mem_we, mem_addr, mem_be, mem_wdata}, 1'b0);
        check("async_reset_rdata", r0_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("no_rvalid_after_reset", r0_rvalid, 1'b0);
        end

        for (int t = 0; t < 300; t++) begin
            logic p, we, xerr;
            logic [31:0] a, wd;
            logic [2:0] d;
            int n;
            p  = 1'($urandom);
            we = 1'($urandom);
            a  = ($urandom & 32'hFFFFC000) | 32'($urandom_range(0, 63));
            wd = $urandom;
            d  = 3'($urandom_range(0, 7));
            n  = size_of(d);
            xerr = (n == 0) || (int'(a[1:0]) % n != 0);
            txn(p, we, a, wd, d, xerr, xerr ? 4'b0 : ref_be(a, d), xerr ? 32'b0 : ref_wd(wd, d),
                a[AW+1:2], (we || xerr) ? 32'b0 : ref_load(a, d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port, synchronous-read data memory between two requesters.
  - Port 0 is the CPU load/store port (mem_w, Addr_out, Data_out, Digit).
  - Port 1 is a loader/debug master.
- Sequences each access through a small FSM and generates byte-lane enables and write-data replication from the Digit width code.
- Aligns and sign/zero-extends read data.
- Arbitrates round-robin, or with fixed priority when configured.

Parameters:
AW, 12, memory word-address width (memory holds 2^AW 32-bit words)
PRIO_FIXED, 0, 0 = round-robin; 1 = port 0 always wins when both request

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rN_req  in  1  port N (N=0,1) request; hold with fields stable until rN_gnt
rN_we  in  1  port N write (1) / read (0)
rN_addr  in  32  port N byte address
rN_wdata  in  32  port N store data, right-justified
rN_digit  in  3  port N width code (package constants)
rN_gnt  out  1  one-cycle pulse: request accepted; port N may drop or change req
rN_rvalid  out  1  one-cycle pulse: rN_rdata valid (reads only)
rN_rdata  out  32  port N aligned, extended read data
rN_err  out  1  one-cycle pulse together with rN_gnt: misaligned or illegal width, no memory access
mem_en  out  1  memory strobe
mem_we  out  1  memory write
mem_addr  out  AW  word address = addr[AW+1:2]; upper address bits ignored
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0; mem_be = 0000.
  - last_grant = 1, so port 0 wins the first contention.
  - Any in-flight transaction is dropped; the requester must reissue.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on a clock edge with any rN_req=1:
  - Select a winner:
    - One requester: it wins.
    - Both, PRIO_FIXED=1: port 0 wins.
    - Both, PRIO_FIXED=0: the port other than last_grant wins.
  - Register the winner's we/addr/wdata/digit; update last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - Pulse rN_gnt for the winner.
  - Legal access: mem_en=1, with mem_we/mem_addr/mem_be/mem_wdata driven from the registered copy.
    - Write goes to IDLE.
    - Read goes to RESP.
  - Illegal access: mem_en=0, rN_err=1 with gnt, go to IDLE. Illegal means any of:
    - word with addr[1:0]!=0
    - half with addr[0]=1
    - undefined digit code
- RESP (one cycle):
  - Align and extend mem_rdata; register it into rN_rdata.
  - rN_rvalid=1 in the following cycle (registered).
  - Go to IDLE; the next arbitration may overlap the rvalid cycle.
- Latencies, with req sampled at edge k:
  - gnt and mem_en during cycle k+1.
  - mem_rdata during k+2.
  - rN_rvalid/rN_rdata during k+3.
  - Throughput: write one per 2 cycles, read one per 3 cycles.
- rN_rdata holds its last value until the next read completes on that port.
- Byte lanes:
  - word: be=1111, wdata=wdata.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - byte: be = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
- Read align: shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend from bit 7 or 15 according to the digit code.
- A req dropped before gnt is simply not granted.
- A request captured in IDLE completes regardless of later req changes.
- Simultaneous new requests during ACCESS/RESP wait; no queueing beyond the held req level.

Decomposition:
- Package dm_pkg holds:
  - Digit codes: DIG_W=3'b000, DIG_H=3'b001, DIG_B=3'b010, DIG_HU=3'b011, DIG_BU=3'b100; 101–111 are illegal.
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
- Sub-module dm_lane_align (combinational) holds:
  - the illegal-access check;
  - be/wdata generation from (addr[1:0], digit, wdata);
  - read alignment/extension.
- The arbiter and FSM stay in dmem_arbiter.

Test Plan:
- Reset: assert reset=0 during RESP of a port-0 read -> all outputs 0 immediately, no r0_rvalid afterwards; after release, next r0 req is granted normally.
- Word write then signed byte read, port 0:
  - SW 0xDEADBEEF to addr 0x10 -> mem_addr=4, mem_be=1111, mem_we=1, one r0_gnt pulse.
  - LB at 0x13 with mem_rdata=0xDEADBEEF -> r0_rdata=0xFFFFFFDE, r0_rvalid at k+3.
- Half/byte lanes:
  - LHU at 0x12 -> r0_rdata=0x0000DEAD.
  - SB 0x81 to 0x11 -> mem_be=0010, mem_wdata=0x81818181.
  - SH 0x1234 to 0x12 -> mem_be=1100, mem_wdata=0x12341234.
- Contention: both ports hold reads continuously:
  - PRIO_FIXED=0 -> gnt order r0, r1, r0, r1.
  - PRIO_FIXED=1 -> r1_gnt never asserts while r0_req is held.
- Errors: r1 word read at 0x06 -> r1_gnt=r1_err=1 for one cycle, mem_en stays 0, no r1_rvalid; digit=3'b111 at 0x00 -> same.
- Address wrap: r0 write to 0xFFFF_C004 with AW=12 -> mem_addr=0x001.
